serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 106 ++++++++++
 tb/tb_serial_subtractor.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;

    modport master (
        output start, a, b, b_in,
        input  ready, busy, done, diff, b_out, ovf
    );

    modport slave (
        input  start, a, b, b_in,
        output ready, busy, done, diff, b_out, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, LSB first, one bit per clock,
// using a single borrow cell and operand/result shift registers.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;

    logic             x;
    logic             y;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    // NOTE: every always_comb output is assigned unconditionally so no latch is inferred.
    always_comb begin
        x        = a_sh[0];
        y        = b_sh[0];
        d        = x ^ y ^ br;
        br_next  = (~x & y) | (~(x ^ y) & br);
        // New bit enters from the MSB side; the cast keeps this legal for WIDTH=1.
        res_next = (res_sh >> 1) | (WIDTH'(d) << (WIDTH - 1));
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bus.ready  <= 1'b1;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.diff   <= '0;
            bus.b_out  <= 1'b0;
            bus.ovf    <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh      <= bus.a;
                        b_sh      <= bus.b;
                        br        <= bus.b_in;
                        a_msb     <= bus.a[WIDTH-1];
                        b_msb     <= bus.b[WIDTH-1];
                        cnt       <= '0;
                        state     <= RUN;
                        bus.ready <= 1'b0;
                        bus.busy  <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br     <= br_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        state     <= DONE;
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        bus.diff  <= res_next;
                        bus.b_out <= br_next;
                        bus.ovf   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    bus.done  <= 1'b0;
                    bus.ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed and random subtractions against an arithmetic reference model.
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();
    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic, unsigned and signed.
    function automatic res_t ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int   ua;
        int   ub;
        int   sa;
        int   sb;
        int   bi;
        int   ur;
        int   sr;
        res_t r;
        ua   = int'(a);
        ub   = int'(b);
        sa   = $signed(a);
        sb   = $signed(b);
        bi   = bin ? 1 : 0;
        ur   = ua - ub - bi;
        sr   = sa - sb - bi;
        r.d  = ur[W-1:0];
        r.bo = (ur < 0);
        r.ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return r;
    endfunction

    // Cycle-level expectation: one idle cycle, W run cycles, one done cycle.
    logic         exp_ready = 1'b1;
    logic         exp_busy  = 1'b0;
    logic         exp_done  = 1'b0;
    logic [W-1:0] exp_diff  = '0;
    logic         exp_bout  = 1'b0;
    logic         exp_ovf   = 1'b0;
    res_t         pend      = '0;
    int           remaining = 0;
    logic         cmp_en    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_ready <= 1'b1;
            exp_busy  <= 1'b0;
            exp_done  <= 1'b0;
            exp_diff  <= '0;
            exp_bout  <= 1'b0;
            exp_ovf   <= 1'b0;
            remaining <= 0;
        end else if (exp_done) begin
            exp_done  <= 1'b0;
            exp_ready <= 1'b1;
        end else if (exp_ready) begin
            if (bus.start) begin
                pend      <= ref_sub(bus.a, bus.b, bus.b_in);
                exp_ready <= 1'b0;
                exp_busy  <= 1'b1;
                remaining <= W;
            end
        end else if (exp_busy) begin
            remaining <= remaining - 1;
            if (remaining == 1) begin
                exp_busy <= 1'b0;
                exp_done <= 1'b1;
                exp_diff <= pend.d;
                exp_bout <= pend.bo;
                exp_ovf  <= pend.ov;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("ready", bus.ready, exp_ready);
            check("busy", bus.busy, exp_busy);
            check("done", bus.done, exp_done);
            check("diff", bus.diff, exp_diff);
            check("b_out", bus.b_out, exp_bout);
            check("ovf", bus.ovf, exp_ovf);
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.b_in  = bin;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 40);
        check("done_seen", bus.done, 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] d, input logic bo, input logic ov);
        int n;
        start_op(a, b, bin);
        wait_done(n);
        check("latency", n, W);
        check("op_diff", bus.diff, d);
        check("op_b_out", bus.b_out, bo);
        check("op_ovf", bus.ovf, ov);
        @(negedge clk);
        check("ready_after", bus.ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   pulses;
        int   last;
        res_t r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.b_in  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_diff", bus.diff, 0);
        check("rst_b_out", bus.b_out, 0);
        check("rst_ovf", bus.ovf, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        run_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // Start and input changes during RUN must be ignored.
        start_op(8'h5A, 8'h23, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        check("ign_latency", n, W - 3);
        check("ign_diff", bus.diff, 8'h37);
        start_op(8'h05, 8'h03, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_diff", bus.diff, 8'h37);
        wait_done(n);
        check("next_diff", bus.diff, 8'h02);
        @(negedge clk);

        // Held start: back-to-back operations every W+2 cycles.
        bus.a     = 8'h05;
        bus.b     = 8'h03;
        bus.b_in  = 1'b0;
        bus.start = 1'b1;
        pulses    = 0;
        last      = 0;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (bus.done) begin
                if (pulses > 0) check("period", i - last, W + 2);
                check("held_diff", bus.diff, 8'h02);
                last = i;
                pulses++;
            end
        end
        check("held_pulses", pulses, 3);
        bus.start = 1'b0;
        wait_done(n);
        @(negedge clk);

        // Asynchronous reset while bit 4 is in flight.
        start_op(8'h5A, 8'h23, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", bus.ready, 1);
        check("arst_busy", bus.busy, 0);
        check("arst_diff", bus.diff, 0);
        check("arst_b_out", bus.b_out, 0);
        check("arst_ovf", bus.ovf, 0);
        repeat (2) begin
            @(negedge clk);
            check("arst_no_done", bus.done, 0);
        end
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        run_op(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            r = ref_sub(ra, rb, rbin);
            run_op(ra, rb, rbin, r.d, r.bo, r.ov);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
